// File: rtl/ball_motion_sequencer.sv
// Ball motion sequencer: tick divider, engine strobe sequencing, ball position and lives.
// Optional PAUSE_EN macro lets the pause input freeze the move-tick counter while in RUN.
module ball_motion_sequencer #(
    parameter int TICK_DIV   = 250000,
    parameter int STEP       = 2,
    parameter int START_Y    = 400,
    parameter int PADDLE_OFS = 34,
    parameter int LIVES      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serve,
    input  logic       pause,
    input  logic [9:0] paddle_x,
    input  logic [1:0] direction_in,
    input  logic       lock_in,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_update,
    output logic       engine_clear,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] POS_MAX = 11'd1023;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] MOVE  = 3'd3;
    localparam logic [2:0] LOST  = 3'd4;
    localparam logic [2:0] OVER  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    lives_q, lives_d;
    logic          s1_q, s2_q, s3_q;
    logic          lock_prev_q;
    logic          serve_edge;
    logic          lock_edge;
    logic          pause_act;
    logic          in_play;

`ifdef PAUSE_EN
    assign pause_act = pause;
`else
    logic pause_unused;
    assign pause_unused = pause;
    assign pause_act    = 1'b0;
`endif

    function automatic logic [9:0] step_dn(input logic [9:0] v);
        logic [10:0] w;
        w = {1'b0, v};
        step_dn = (w < STEP_W) ? 10'd0 : 10'(w - STEP_W);
    endfunction

    function automatic logic [9:0] step_up(input logic [9:0] v);
        logic [10:0] w;
        w = {1'b0, v} + STEP_W;
        step_up = (w > POS_MAX) ? 10'd1023 : w[9:0];
    endfunction

    assign serve_edge = s2_q & ~s3_q;
    assign lock_edge  = lock_in & ~lock_prev_q;
    assign in_play    = (state_q == RUN) || (state_q == CHECK) || (state_q == MOVE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        lives_d      = lives_q;
        dir_update   = 1'b0;
        engine_clear = 1'b0;
        unique case (state_q)
            IDLE: begin
                x_d = paddle_x + 10'(PADDLE_OFS);
                y_d = 10'(START_Y);
                if (serve_edge) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!pause_act) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d      = '0;
                        dir_update = 1'b1;
                        state_d    = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: state_d = MOVE;
            MOVE: begin
                y_d     = direction_in[1] ? step_dn(y_q) : step_up(y_q);
                x_d     = direction_in[0] ? step_dn(x_q) : step_up(x_q);
                state_d = RUN;
            end
            LOST: begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_d = OVER;
                end else begin
                    engine_clear = 1'b1;
                    state_d      = IDLE;
                end
            end
            OVER: state_d = OVER;
            default: state_d = IDLE;
        endcase
        // A fresh ball-lost edge pre-empts whatever the play states planned.
        if (lock_edge && in_play) begin
            state_d    = LOST;
            cnt_d      = cnt_q;
            x_d        = x_q;
            y_d        = y_q;
            dir_update = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= 10'(START_Y);
            lives_q     <= 2'(LIVES);
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            lock_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            lives_q     <= lives_d;
            s1_q        <= serve;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            lock_prev_q <= lock_in;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign lives     = lives_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Scoreboard bench for ball_motion_sequencer: expected strobe/clear/over events
// are queued by the stimulus and checked by an independent monitor.
module tb_ball_motion_sequencer;

    logic       clk;
    logic       rst_n;
    logic       serve;
    logic       pause;
    logic [9:0] paddle_x;
    logic [1:0] direction_in;
    logic       lock_in;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       dir_update;
    logic       engine_clear;
    logic [1:0] lives;
    logic       game_over;

    ball_motion_sequencer #(
        .TICK_DIV(4), .STEP(2), .START_Y(400), .PADDLE_OFS(34), .LIVES(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .serve(serve), .pause(pause),
        .paddle_x(paddle_x), .direction_in(direction_in), .lock_in(lock_in),
        .ball_x(ball_x), .ball_y(ball_y), .dir_update(dir_update),
        .engine_clear(engine_clear), .lives(lives), .game_over(game_over)
    );

    typedef struct {
        int kind;
        int cyc;
        int x;
        int y;
        int lv;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    logic go_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 dir_update, 1 engine_clear, 2 game_over rise, 3 both strobes at once
    always @(negedge clk) begin
        int  k;
        ev_t e;
        logic go_rise;
        go_rise = game_over && !go_prev;
        go_prev = game_over;
        if (dir_update || engine_clear || go_rise) begin
            if (dir_update && engine_clear) k = 3;
            else if (dir_update)            k = 0;
            else if (engine_clear)          k = 1;
            else                            k = 2;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event kind=%0d cyc=%0d x=%0d y=%0d lives=%0d",
                         k, cyc, ball_x, ball_y, lives);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != k || e.cyc != cyc || e.x != int'(ball_x) ||
                    e.y != int'(ball_y) || e.lv != int'(lives)) begin
                    errors++;
                    $display("FAIL event got kind=%0d cyc=%0d x=%0d y=%0d lives=%0d expected kind=%0d cyc=%0d x=%0d y=%0d lives=%0d",
                             k, cyc, ball_x, ball_y, lives,
                             e.kind, e.cyc, e.x, e.y, e.lv);
                end
            end
        end
    end

    task automatic nxt(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic until_cyc(input int c);
        while (cyc < c) nxt(1);
    endtask

    task automatic push(input int k, input int c, input int x, input int y, input int lv);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.x    = x;
        e.y    = y;
        e.lv   = lv;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
        end
    endtask

    function automatic int mdn(input int v);
        return (v < 2) ? 0 : v - 2;
    endfunction

    function automatic int mup(input int v);
        return (v > 1021) ? 1023 : v + 2;
    endfunction

    initial begin
        int n, m, s, p, t3, x, y;
        rst_n        = 1'b0;
        serve        = 1'b0;
        pause        = 1'b0;
        paddle_x     = 10'd300;
        direction_in = 2'b00;
        lock_in      = 1'b0;
        nxt(2);
        chk("rst_ball_x", ball_x, 0);
        chk("rst_ball_y", ball_y, 400);
        chk("rst_lives", lives, 3);
        chk("rst_dir_update", dir_update, 0);
        chk("rst_engine_clear", engine_clear, 0);
        chk("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        nxt(1);
        chk("park_x_300", ball_x, 334);
        paddle_x = 10'd500;
        nxt(1);
        chk("park_x_500", ball_x, 534);
        paddle_x = 10'd300;
        nxt(2);

        // serve, north-east steps, lock during CHECK
        direction_in = 2'b10;
        n = cyc;
        serve = 1'b1;
        push(0, n + 6, 334, 400, 3);
        push(0, n + 12, 336, 398, 3);
        push(0, n + 18, 338, 396, 3);
        push(1, n + 20, 338, 396, 3);
        nxt(3);
        serve = 1'b0;
        until_cyc(n + 19);
        lock_in = 1'b1;
        until_cyc(n + 21);
        chk("lives_after_loss1", lives, 2);
        nxt(1);
        chk("repark_x", ball_x, 334);
        chk("repark_y", ball_y, 400);

        // sticky lock stays high through second serve; west saturation
        paddle_x = 10'd1;
        nxt(2);
        direction_in = 2'b11;
        m = cyc;
        serve = 1'b1;
        x = 35;
        y = 400;
        for (int k = 0; k < 20; k++) begin
            push(0, m + 6 + 6 * k, x, y, 2);
            x = mdn(x);
            y = mdn(y);
        end
        push(1, m + 124, x, y, 2);
        nxt(3);
        serve = 1'b0;
        until_cyc(m + 121);
        lock_in = 1'b0;
        until_cyc(m + 123);
        lock_in = 1'b1;
        until_cyc(m + 126);
        lock_in = 1'b0;
        chk("lives_after_loss2", lives, 1);
        chk("repark_x_paddle1", ball_x, 35);

        // third serve: east and north saturation, final loss
        paddle_x = 10'd988;
        nxt(2);
        direction_in = 2'b10;
        s = cyc;
        serve = 1'b1;
        x = 1022;
        y = 400;
        for (int k = 0; k < 203; k++) begin
            push(0, s + 6 + 6 * k, x, y, 1);
            x = mup(x);
            y = mdn(y);
        end
        push(2, s + 1221, x, y, 0);
        nxt(3);
        serve = 1'b0;
        until_cyc(s + 1219);
        lock_in = 1'b1;
        until_cyc(s + 1222);
        serve = 1'b1;
        nxt(3);
        serve = 1'b0;
        paddle_x = 10'd100;
        nxt(20);
        chk("over_game_over", game_over, 1);
        chk("over_ball_x", ball_x, 1023);
        chk("over_ball_y", ball_y, 0);
        chk("over_lives", lives, 0);

        rst_n   = 1'b0;
        lock_in = 1'b0;
        paddle_x = 10'd300;
        #1;
        chk("rerst_lives", lives, 3);
        chk("rerst_game_over", game_over, 0);
        chk("rerst_ball_x", ball_x, 0);
        nxt(2);
        rst_n = 1'b1;
        nxt(2);

        // pause mid-RUN
        direction_in = 2'b00;
        p = cyc;
`ifdef PAUSE_EN
        t3 = p + 38;
`else
        t3 = p + 18;
`endif
        serve = 1'b1;
        push(0, p + 6, 334, 400, 3);
        push(0, p + 12, 336, 402, 3);
        push(0, t3, 338, 404, 3);
        push(1, t3 + 2, 338, 404, 3);
        nxt(3);
        serve = 1'b0;
        fork
            begin
                until_cyc(p + 16);
                pause = 1'b1;
                nxt(20);
                pause = 1'b0;
            end
            begin
                until_cyc(t3 + 1);
                lock_in = 1'b1;
            end
        join
        until_cyc(t3 + 5);
        chk("lives_after_pause_loss", lives, 2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
